// File: rtl/implication_monitor.sv
`default_nettype none
// ============================================================================
// Module      : implication_monitor
// Description : In-hardware checker for "antecedent |-> ##DELAY consequent"
//               with fail pulse, sticky flag, saturating counters and a
//               first-failure timestamp.
// Revision    : 1.0 - initial release
// ============================================================================
module implication_monitor #(
    parameter int DELAY        = 1,
    parameter int CNT_WIDTH    = 8,
    parameter bit STOP_ON_FAIL = 1'b0
)(
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 antecedent,
    input  logic                 consequent,
    output logic                 fail,
    output logic                 fail_sticky,
    output logic [CNT_WIDTH-1:0] pass_count,
    output logic [CNT_WIDTH-1:0] fail_count,
    output logic [CNT_WIDTH-1:0] first_fail_time,
    output logic                 pending
);

    localparam logic [1:0] c_ST_DISABLED = 2'd0;
    localparam logic [1:0] c_ST_ARMED    = 2'd1;
    localparam logic [1:0] c_ST_FAILED   = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [DELAY-1:0]     r_pend;
    logic [DELAY-1:0]     w_pend_shift;
    logic [CNT_WIDTH-1:0] r_ts;
    logic [CNT_WIDTH-1:0] r_pass_count;
    logic [CNT_WIDTH-1:0] r_fail_count;
    logic [CNT_WIDTH-1:0] r_first_fail_time;
    logic                 r_fail;
    logic                 r_fail_sticky;
    logic                 w_active;
    logic                 w_mature;
    logic                 w_pass_evt;
    logic                 w_fail_evt;

    generate
        if (DELAY == 1) begin : g_shift_single
            assign w_pend_shift = antecedent;
        end else begin : g_shift_multi
            assign w_pend_shift = {r_pend[DELAY-2:0], antecedent};
        end
    endgenerate

    // Obligations only advance while armed and enabled; any other cycle discards them.
    assign w_active   = en && (r_state == c_ST_ARMED);
    assign w_mature   = r_pend[DELAY-1];
    assign w_pass_evt = w_active && w_mature && consequent;
    assign w_fail_evt = w_active && w_mature && !consequent;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_DISABLED: begin
                if (en) begin
                    w_state_next = c_ST_ARMED;
                end
            end
            c_ST_ARMED: begin
                if (!en) begin
                    w_state_next = c_ST_DISABLED;
                end else if (w_fail_evt && STOP_ON_FAIL) begin
                    w_state_next = c_ST_FAILED;
                end
            end
            c_ST_FAILED: begin
                w_state_next = c_ST_FAILED;
            end
            default: begin
                w_state_next = c_ST_DISABLED;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state           <= c_ST_DISABLED;
            r_pend            <= '0;
            r_ts              <= '0;
            r_pass_count      <= '0;
            r_fail_count      <= '0;
            r_first_fail_time <= '0;
            r_fail            <= 1'b0;
            r_fail_sticky     <= 1'b0;
        end else if (clear) begin
            r_state           <= en ? c_ST_ARMED : c_ST_DISABLED;
            r_pend            <= '0;
            r_ts              <= '0;
            r_pass_count      <= '0;
            r_fail_count      <= '0;
            r_first_fail_time <= '0;
            r_fail            <= 1'b0;
            r_fail_sticky     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ts    <= r_ts + 1'b1;
            r_fail  <= w_fail_evt;

            if (w_active) begin
                r_pend <= w_pend_shift;
            end else begin
                r_pend <= '0;
            end

            if (w_pass_evt && (r_pass_count != c_CNT_MAX)) begin
                r_pass_count <= r_pass_count + 1'b1;
            end

            if (w_fail_evt) begin
                if (r_fail_count != c_CNT_MAX) begin
                    r_fail_count <= r_fail_count + 1'b1;
                end
                // Timestamp is the counter value at the checking edge itself.
                if (!r_fail_sticky) begin
                    r_fail_sticky     <= 1'b1;
                    r_first_fail_time <= r_ts;
                end
            end
        end
    end

    assign fail            = r_fail;
    assign fail_sticky     = r_fail_sticky;
    assign pass_count      = r_pass_count;
    assign fail_count      = r_fail_count;
    assign first_fail_time = r_first_fail_time;
    assign pending         = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_implication_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_implication_monitor
// Description : Scoreboard bench for implication_monitor, two configurations
//               driven with shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_implication_monitor;

    typedef struct packed {
        logic       fail;
        logic       sticky;
        logic       pending;
        logic [7:0] pass;
        logic [7:0] fcnt;
        logic [7:0] first;
    } exp_t;

    logic CLK = 1'b0;
    logic ASYNCRESETN = 1'b0;
    logic en = 1'b0;
    logic clear = 1'b0;
    logic antecedent = 1'b0;
    logic consequent = 1'b0;

    // Instance A: DELAY=3, CNT_WIDTH=4, keeps checking after failures
    logic       fail_a, sticky_a, pend_a;
    logic [3:0] pass_a, fcnt_a, first_a;
    // Instance B: DELAY=1, CNT_WIDTH=8, stops on first failure
    logic       fail_b, sticky_b, pend_b;
    logic [7:0] pass_b, fcnt_b, first_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Model state, index 0 = instance A, 1 = instance B
    int cyc = 0;
    bit hist[0:4095];
    int m_st[2];
    int m_streak[2];
    int m_ts[2];
    int m_pass[2];
    int m_fcnt[2];
    int m_first[2];
    bit m_fail[2];
    bit m_sticky[2];

    implication_monitor #(.DELAY(3), .CNT_WIDTH(4), .STOP_ON_FAIL(1'b0)) dut_a (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .clear(clear),
        .antecedent(antecedent), .consequent(consequent),
        .fail(fail_a), .fail_sticky(sticky_a), .pass_count(pass_a),
        .fail_count(fcnt_a), .first_fail_time(first_a), .pending(pend_a)
    );

    implication_monitor #(.DELAY(1), .CNT_WIDTH(8), .STOP_ON_FAIL(1'b1)) dut_b (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .clear(clear),
        .antecedent(antecedent), .consequent(consequent),
        .fail(fail_b), .fail_sticky(sticky_b), .pass_count(pass_b),
        .fail_count(fcnt_b), .first_fail_time(first_b), .pending(pend_b)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_st[i]     = 0;
        m_streak[i] = -1;
        m_ts[i]     = 0;
        m_pass[i]   = 0;
        m_fcnt[i]   = 0;
        m_first[i]  = 0;
        m_fail[i]   = 1'b0;
        m_sticky[i] = 1'b0;
    endtask

    // Obligations are tracked as "antecedent seen at cycle c during an unbroken
    // active streak"; one matures D edges later if the streak is still unbroken.
    task automatic model_edge(input int i, input int d, input int w, input bit stop, output exp_t e);
        int  maxc;
        bit  act, pe, fe, pd;
        maxc = (1 << w) - 1;
        if (!ASYNCRESETN) begin
            model_reset(i);
        end else if (clear) begin
            model_reset(i);
            m_st[i] = en ? 1 : 0;
        end else begin
            act = en && (m_st[i] == 1);
            pe  = 1'b0;
            fe  = 1'b0;
            if (act) begin
                if (m_streak[i] < 0) m_streak[i] = cyc;
                if ((cyc - d >= m_streak[i]) && hist[cyc-d]) begin
                    pe = consequent;
                    fe = !consequent;
                end
            end else begin
                m_streak[i] = -1;
            end
            m_fail[i] = fe;
            if (pe && m_pass[i] < maxc) m_pass[i]++;
            if (fe) begin
                if (m_fcnt[i] < maxc) m_fcnt[i]++;
                if (!m_sticky[i]) begin
                    m_sticky[i] = 1'b1;
                    m_first[i]  = m_ts[i];
                end
            end
            m_ts[i] = (m_ts[i] + 1) % (maxc + 1);
            if (m_st[i] == 0 && en)                 m_st[i] = 1;
            else if (m_st[i] == 1 && !en)           m_st[i] = 0;
            else if (m_st[i] == 1 && fe && stop)    m_st[i] = 2;
        end
        pd = 1'b0;
        if (m_streak[i] >= 0) begin
            for (int c = cyc - d + 1; c <= cyc; c++) begin
                if (c >= m_streak[i] && c >= 0 && hist[c]) pd = 1'b1;
            end
        end
        e.fail    = m_fail[i];
        e.sticky  = m_sticky[i];
        e.pending = pd;
        e.pass    = 8'(m_pass[i]);
        e.fcnt    = 8'(m_fcnt[i]);
        e.first   = 8'(m_first[i]);
    endtask

    task automatic compare(input string p, input exp_t e, input logic f, input logic s,
                           input logic pd, input logic [7:0] pc, input logic [7:0] fc,
                           input logic [7:0] ft);
        check_eq({p, ".fail"},            {31'd0, f},  {31'd0, e.fail});
        check_eq({p, ".fail_sticky"},     {31'd0, s},  {31'd0, e.sticky});
        check_eq({p, ".pending"},         {31'd0, pd}, {31'd0, e.pending});
        check_eq({p, ".pass_count"},      {24'd0, pc}, {24'd0, e.pass});
        check_eq({p, ".fail_count"},      {24'd0, fc}, {24'd0, e.fcnt});
        check_eq({p, ".first_fail_time"}, {24'd0, ft}, {24'd0, e.first});
    endtask

    task automatic step(input bit e_in, input bit clr, input bit ant, input bit cons);
        exp_t ea, eb;
        @(negedge CLK);
        en         = e_in;
        clear      = clr;
        antecedent = ant;
        consequent = cons;
        @(posedge CLK);
        hist[cyc] = ant;
        model_edge(0, 3, 4, 1'b0, ea);
        model_edge(1, 1, 8, 1'b1, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        #1;
        if (q_a.size() == 0 || q_b.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            compare("a", q_a.pop_front(), fail_a, sticky_a, pend_a,
                    {4'd0, pass_a}, {4'd0, fcnt_a}, {4'd0, first_a});
            compare("b", q_b.pop_front(), fail_b, sticky_b, pend_b,
                    pass_b, fcnt_b, first_b);
        end
        cyc++;
    endtask

    initial begin
        model_reset(0);
        model_reset(1);

        // Reset held for a few edges
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        ASYNCRESETN = 1'b1;
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Single pass obligation
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1);

        // Single failing obligation
        step(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back triggers with mixed consequents
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Saturation: long run of violations
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (25) step(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("a.fail_count_saturated", {28'd0, fcnt_a}, 32'd15);
        check_eq("b.stop_on_fail_count",   {24'd0, fcnt_b}, 32'd1);

        // Clear re-arms the stop-on-fail instance
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("b.count_after_clear", {24'd0, fcnt_b}, 32'd1);

        // Clear coincident with a maturing violation
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Enable dropped while obligations outstanding
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges, with obligations outstanding
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        ASYNCRESETN = 1'b0;
        #1;
        check_eq("a.async_pending",     {31'd0, pend_a},   32'd0);
        check_eq("a.async_fail_count",  {28'd0, fcnt_a},   32'd0);
        check_eq("a.async_sticky",      {31'd0, sticky_a}, 32'd0);
        check_eq("b.async_pending",     {31'd0, pend_b},   32'd0);
        check_eq("b.async_fail",        {31'd0, fail_b},   32'd0);
        check_eq("b.async_first_time",  {24'd0, first_b},  32'd0);
        model_reset(0);
        model_reset(1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        ASYNCRESETN = 1'b1;

        // Random traffic
        for (int k = 0; k < 250; k++) begin
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
